// File: rtl/configf_pkg.sv
// ============================================================================
// Module  : configf_pkg
// Brief   : Shared types and default widths for the config-flash command host.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package configf_pkg;

  localparam int CONFIGF_ADDR_W = 8;
  localparam int CONFIGF_NUM_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/configf_rr_arb.sv
// ============================================================================
// Module  : configf_rr_arb
// Brief   : Combinational round-robin pick, searching from last_grant+1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module configf_rr_arb
  import configf_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  logic [IDX_W:0] w_idx;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      w_idx = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (w_idx >= (IDX_W+1)'(NUM_CH)) begin
        w_idx = w_idx - (IDX_W+1)'(NUM_CH);
      end
      if (pending[w_idx[IDX_W-1:0]]) begin
        grant = w_idx[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/configf_host_arb.sv
// ============================================================================
// Module  : configf_host_arb
// Brief   : Multi-channel round-robin command host for the config-flash SPI
//           entity. Optional entity watchdog: define CONFIGF_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module configf_host_arb
  import configf_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int ADDR_W         = CONFIGF_ADDR_W,
  parameter int NUM_W          = CONFIGF_NUM_W,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int IDX_W         = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        user_cmd_en_in,
  input  logic [NUM_CH*ADDR_W-1:0] user_addr_in,
  input  logic [NUM_CH*NUM_W-1:0]  user_wrrd_num_in,
  output logic [NUM_CH-1:0]        user_cmd_done_out,
  output logic [NUM_CH-1:0]        user_cmd_err_out,
  output logic                     hst_cmd_en_out,
  output logic [ADDR_W-1:0]        hst_addr_out,
  output logic [NUM_W-1:0]         hst_wrrd_num_out,
  input  logic                     hst_cmd_done_in,
  output logic                     busy_out,
  output logic [IDX_W-1:0]         grant_ch_out
);

  state_t              r_state;
  state_t              w_next;
  logic [NUM_CH-1:0]   r_pending;
  logic [NUM_CH-1:0]   r_ovr_err;
  logic [NUM_CH-1:0]   w_clr;
  logic [NUM_CH-1:0]   w_accept;
  logic [NUM_CH-1:0]   w_grant_oh;
  logic [ADDR_W-1:0]   r_addr [NUM_CH];
  logic [NUM_W-1:0]    r_num  [NUM_CH];
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    w_arb_grant;
  logic                w_arb_valid;
  logic                w_grant_en;
  logic                w_zero_len;
  logic                w_to_hit;
  logic                w_timed_out;
  logic [ADDR_W-1:0]   r_hst_addr;
  logic [NUM_W-1:0]    r_hst_num;

  configf_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .pending    (r_pending),
    .last_grant (r_last_grant),
    .grant      (w_arb_grant),
    .valid      (w_arb_valid)
  );

  assign w_grant_oh = NUM_CH'(1) << r_grant;
  assign w_clr      = (r_state == ST_DONE) ? w_grant_oh : '0;
  assign w_grant_en = (r_state == ST_IDLE) && w_arb_valid;
  assign w_zero_len = (r_num[w_arb_grant] == '0);

  // A pulse landing on the completion cycle of its own channel is a new command.
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_accept[c] = user_cmd_en_in[c] && (!r_pending[c] || w_clr[c]);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_pending[c] <= 1'b0;
          r_ovr_err[c] <= 1'b0;
          r_addr[c]    <= '0;
          r_num[c]     <= '0;
        end else begin
          r_pending[c] <= w_accept[c] || (r_pending[c] && !w_clr[c]);
          r_ovr_err[c] <= user_cmd_en_in[c] && r_pending[c] && !w_clr[c];
          if (w_accept[c]) begin
            r_addr[c] <= user_addr_in[c*ADDR_W +: ADDR_W];
            r_num[c]  <= user_wrrd_num_in[c*NUM_W +: NUM_W];
          end
        end
      end
    end
  endgenerate

  // Zero-length grants skip the entity, so the host fields keep the last issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= IDX_W'(NUM_CH - 1);
      r_grant      <= '0;
      r_hst_addr   <= '0;
      r_hst_num    <= '0;
    end else if (w_grant_en) begin
      r_last_grant <= w_arb_grant;
      r_grant      <= w_arb_grant;
      if (!w_zero_len) begin
        r_hst_addr <= r_addr[w_arb_grant];
        r_hst_num  <= r_num[w_arb_grant];
      end
    end
  end

`ifdef CONFIGF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_timed_out;

  // A done arriving on the final watchdog cycle still completes normally.
  assign w_to_hit    = (r_state == ST_WAIT) && !hst_cmd_done_in &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_timed_out = r_timed_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_to_cnt    <= (r_state == ST_WAIT) ? r_to_cnt + CNT_W'(1) : '0;
      r_timed_out <= w_to_hit;
    end
  end
`else
  // Watchdog not built; the parameter is referenced only to keep it live.
  assign w_to_hit    = (TIMEOUT_CYCLES < 0);
  assign w_timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_next = w_zero_len ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (hst_cmd_done_in || w_to_hit) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    hst_cmd_en_out    = (r_state == ST_ISSUE);
    busy_out          = (r_state != ST_IDLE);
    user_cmd_done_out = '0;
    user_cmd_err_out  = r_ovr_err;
    if (r_state == ST_DONE) begin
      if (w_timed_out) begin
        user_cmd_err_out = r_ovr_err | w_grant_oh;
      end else begin
        user_cmd_done_out = w_grant_oh;
      end
    end
  end

  assign hst_addr_out     = r_hst_addr;
  assign hst_wrrd_num_out = r_hst_num;
  assign grant_ch_out     = r_grant;

endmodule

`default_nettype wire
